// File: rtl/alu_defs.sv
// alu_defs: function codes and the result-stage state encoding.
// Shared by the shifter, the ALU and alu_result_stage.
package alu_defs;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MUL_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/alu_result_stage_hilo_reg.sv
// hilo_reg: 64-bit HI/LO register with load enable and async active-low clear.
// Ports:
//   clk        - rising-edge clock
//   rst_n      - async active-low clear (HI, LO and hilo_valid go to 0)
//   load       - load din into {HI, LO} and set hilo_valid
//   din        - 64-bit product, HI = [63:32], LO = [31:0]
//   hi, lo     - current register halves
//   hilo_valid - set once a product has been loaded
module hilo_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [63:0] din,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        hilo_valid
);

  logic [63:0] hilo_d, hilo_q;
  logic        valid_d, valid_q;

  always_comb begin
    hilo_d  = hilo_q;
    valid_d = valid_q;
    if (load) begin
      hilo_d  = din;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hilo_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      hilo_q  <= hilo_d;
      valid_q <= valid_d;
    end
  end

  assign hi         = hilo_q[63:32];
  assign lo         = hilo_q[31:0];
  assign hilo_valid = valid_q;

endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: registered result stage after the ALU and barrel shifter.
// Selects ALU / shifter / HI / LO by function code into a registered dataOut,
// and sequences the MULTU wait, loading the product into HI/LO at its end.
// Ports:
//   clk        - rising-edge clock
//   reset      - async active-low reset
//   Signal     - 6-bit function code
//   aluOut     - ALU result (same cycle as Signal)
//   shiftOut   - shifter result (same cycle as Signal)
//   mulProduct - 64-bit product, sampled on the last wait edge
//   dataOut    - registered stage result
//   busy       - MULTU in flight; upstream holds Signal
//   hiloValid  - HI/LO hold a completed product
module alu_result_stage
  import alu_defs::*;
#(
  parameter int unsigned MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  Signal,
  input  logic [31:0] aluOut,
  input  logic [31:0] shiftOut,
  input  logic [63:0] mulProduct,
  output logic [31:0] dataOut,
  output logic        busy,
  output logic        hiloValid
);

  localparam logic [5:0] CNT_LAST = 6'(MUL_CYCLES - 1);

  state_e      state_d, state_q;
  logic [5:0]  cnt_d, cnt_q;
  logic [31:0] data_d, data_q;
  logic        hilo_load;
  logic [31:0] hi, lo;

  hilo_reg u_hilo_reg (
    .clk        (clk),
    .rst_n      (reset),
    .load       (hilo_load),
    .din        (mulProduct),
    .hi         (hi),
    .lo         (lo),
    .hilo_valid (hiloValid)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    hilo_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        case (Signal)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: data_d = aluOut;
          FN_SRL:   data_d = shiftOut;
          FN_MFHI:  data_d = hi;
          FN_MFLO:  data_d = lo;
          FN_MULTU: begin
            state_d = ST_MUL_WAIT;
            cnt_d   = '0;
          end
          default:  data_d = '0;
        endcase
      end
      ST_MUL_WAIT: begin
        // Signal is ignored here; dataOut holds until the wait ends.
        if (cnt_q == CNT_LAST) begin
          hilo_load = 1'b1;
          state_d   = ST_IDLE;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  assign dataOut = data_q;
  assign busy    = (state_q == ST_MUL_WAIT);

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: the driver updates a behavioural
// model each cycle and queues the expected post-edge outputs; the monitor
// pops and compares after every rising edge.
module tb_alu_result_stage;

  localparam int unsigned MULC = 32;

  localparam logic [5:0] C_ADD   = 6'b100000;
  localparam logic [5:0] C_SUB   = 6'b100010;
  localparam logic [5:0] C_AND   = 6'b100100;
  localparam logic [5:0] C_OR    = 6'b100101;
  localparam logic [5:0] C_SLT   = 6'b101010;
  localparam logic [5:0] C_SRL   = 6'b000010;
  localparam logic [5:0] C_MULTU = 6'b011001;
  localparam logic [5:0] C_MFHI  = 6'b010000;
  localparam logic [5:0] C_MFLO  = 6'b010010;
  localparam logic [5:0] C_NOP   = 6'b111111;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  Signal;
  logic [31:0] aluOut, shiftOut;
  logic [63:0] mulProduct;
  logic [31:0] dataOut;
  logic        busy, hiloValid;

  alu_result_stage #(.MUL_CYCLES(MULC)) dut (
    .clk        (clk),
    .reset      (reset),
    .Signal     (Signal),
    .aluOut     (aluOut),
    .shiftOut   (shiftOut),
    .mulProduct (mulProduct),
    .dataOut    (dataOut),
    .busy       (busy),
    .hiloValid  (hiloValid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        busy;
    logic        valid;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: remaining wait cycles instead of a state machine.
  int unsigned m_rem   = 0;
  logic [31:0] m_data  = '0;
  logic [31:0] m_hi    = '0;
  logic [31:0] m_lo    = '0;
  logic        m_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
    end
  endtask

  task automatic model_clear();
    m_rem = 0; m_data = '0; m_hi = '0; m_lo = '0; m_valid = 1'b0;
  endtask

  function automatic bit is_alu_op(input logic [5:0] s);
    return s == C_ADD || s == C_SUB || s == C_AND || s == C_OR || s == C_SLT;
  endfunction

  // Drive one cycle at the current falling edge, then advance to the next one.
  task automatic step(input logic [5:0] s, input logic [31:0] a, input logic [31:0] sh,
                      input logic [63:0] p);
    exp_t e;
    Signal = s; aluOut = a; shiftOut = sh; mulProduct = p;
    if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) begin
        m_hi = p[63:32];
        m_lo = p[31:0];
        m_valid = 1'b1;
      end
    end else if (s == C_MULTU) begin
      m_rem = MULC;
    end else if (is_alu_op(s)) begin
      m_data = a;
    end else if (s == C_SRL) begin
      m_data = sh;
    end else if (s == C_MFHI) begin
      m_data = m_hi;
    end else if (s == C_MFLO) begin
      m_data = m_lo;
    end else begin
      m_data = '0;
    end
    e.data = m_data; e.busy = (m_rem > 0); e.valid = m_valid;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic pulse_reset(input int unsigned cycles);
    exp_t e;
    reset = 1'b0;
    #1;
    check("rst_dataOut", dataOut, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_hiloValid", {31'b0, hiloValid}, 32'h0);
    model_clear();
    Signal = C_NOP;
    e.data = '0; e.busy = 1'b0; e.valid = 1'b0;
    repeat (cycles) begin
      exp_q.push_back(e);
      @(negedge clk);
    end
    reset = 1'b1;
  endtask

  function automatic logic [5:0] rand_sig();
    logic [5:0] tbl [10];
    int unsigned k;
    tbl = '{C_ADD, C_SUB, C_AND, C_OR, C_SLT, C_SRL, C_MULTU, C_MFHI, C_MFLO, C_MFHI};
    k = $urandom_range(0, 10);
    if (k == 10) return 6'($urandom);
    return tbl[k];
  endfunction

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("dataOut", dataOut, e.data);
        check("busy", {31'b0, busy}, {31'b0, e.busy});
        check("hiloValid", {31'b0, hiloValid}, {31'b0, e.valid});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] p;
    int unsigned wait_cycles;
    reset = 1'b0; Signal = C_NOP; aluOut = '0; shiftOut = '0; mulProduct = '0;
    repeat (2) @(negedge clk);
    check("init_dataOut", dataOut, 32'h0);
    check("init_busy", {31'b0, busy}, 32'h0);
    check("init_hiloValid", {31'b0, hiloValid}, 32'h0);
    reset = 1'b1;

    // Directed selects
    step(C_SRL, 32'hDEAD_BEEF, 32'h0000_00F0, 64'h0);
    step(C_ADD, 32'h0000_0007, 32'h1234_5678, 64'h0);
    step(C_NOP, 32'h5555_5555, 32'hAAAA_AAAA, 64'h0);
    step(C_SUB, 32'hCAFE_F00D, 32'h0, 64'h0);

    // MULTU with quiet inputs, then read back HI and LO
    p = 64'h0000_0001_8000_0000;
    step(C_MULTU, 32'h1, 32'h2, p);
    repeat (MULC) step(C_NOP, $urandom, $urandom, p);
    step(C_MFHI, $urandom, $urandom, p);
    step(C_MFLO, $urandom, $urandom, p);

    // Signal ignored while busy: ADD and another MULTU during the wait
    step(C_ADD, 32'h0000_0042, 32'h0, 64'h0);
    p = {$urandom, $urandom};
    step(C_MULTU, 32'h0, 32'h0, p);
    for (int unsigned i = 0; i < MULC; i++)
      step((i % 2 == 0) ? C_ADD : C_MULTU, $urandom, $urandom, p);
    step(C_MFLO, $urandom, $urandom, p);
    step(C_MFHI, $urandom, $urandom, p);

    // Abort a multiply at cnt = 10
    step(C_MULTU, 32'h0, 32'h0, 64'hFFFF_FFFF_FFFF_FFFF);
    repeat (10) step(C_NOP, $urandom, $urandom, 64'hFFFF_FFFF_FFFF_FFFF);
    pulse_reset(2);
    step(C_MFHI, $urandom, $urandom, 64'h0);
    step(C_MFLO, $urandom, $urandom, 64'h0);
    p = 64'h1234_5678_9ABC_DEF0;
    step(C_MULTU, 32'h0, 32'h0, p);
    repeat (MULC) step(C_NOP, $urandom, $urandom, p);
    step(C_MFHI, $urandom, $urandom, 64'h0);

    // Randomized traffic with a changing product and occasional resets
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 299) == 0) pulse_reset($urandom_range(1, 3));
      else step(rand_sig(), $urandom, $urandom, {$urandom, $urandom});
    end
    step(C_MFHI, 32'h0, 32'h0, 64'h0);

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(negedge clk);
      wait_cycles++;
    end
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
